// File: rtl/dram_pkg.sv
// dram_pkg: shared types and DDR4 command-bus decode for the DRAM-side command receiver
package dram_pkg;
    typedef enum logic [3:0] {
        CMD_NONE, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF, CMD_MRS, CMD_ZQC, CMD_RFU
    } cmd_t;
    typedef enum logic [3:0] {
        ERR_NONE, ERR_RFC_BUSY, ERR_ACT_OPEN, ERR_TRP, ERR_NOT_OPEN, ERR_TRCD, ERR_TRAS, ERR_REF_OPEN, ERR_RFU
    } err_t;
    typedef enum logic [1:0] {BANK_IDLE, BANK_ACTIVE, BANK_PRECH} bank_state_t;
    localparam logic [2:0] RCW_MRS = 3'b000;
    localparam logic [2:0] RCW_REF = 3'b001;
    localparam logic [2:0] RCW_PRE = 3'b010;
    localparam logic [2:0] RCW_RFU = 3'b011;
    localparam logic [2:0] RCW_WR  = 3'b100;
    localparam logic [2:0] RCW_RD  = 3'b101;
    localparam logic [2:0] RCW_ZQC = 3'b110;
    localparam int AP_BIT = 10;
    // Decode of a selected (CS_n=0, CKE=1) bus cycle; NOP maps to CMD_NONE.
    function automatic cmd_t decode_cmd(input logic act_n, input logic [2:0] rcw, input logic a10);
        if (!act_n) return CMD_ACT;
        case (rcw)
            RCW_MRS: return CMD_MRS;
            RCW_REF: return CMD_REF;
            RCW_PRE: return a10 ? CMD_PREA : CMD_PRE;
            RCW_RFU: return CMD_RFU;
            RCW_WR:  return CMD_WR;
            RCW_RD:  return CMD_RD;
            RCW_ZQC: return CMD_ZQC;
            default: return CMD_NONE;
        endcase
    endfunction
endpackage

// File: rtl/dram_bank_fsm.sv
// dram_bank_fsm: one DDR4 bank - IDLE/ACTIVE/PRECH state, open row, tRCD/tRAS/tRP counters
// Ports: CLK/nRST clock and async active-low reset; i_act ACT to this bank; i_pre PRE to this
// bank or PREA; i_rdwr_ap RD/WR with auto-precharge to this bank; i_row row for ACT;
// o_idle bank accepts ACT this edge; o_active ACTIVE; o_trp_busy precharge still running;
// o_rcd_busy/o_ras_busy counters nonzero; o_row latched open row.
module dram_bank_fsm
    import dram_pkg::*;
#(
    parameter int ROW_BITS = 16,
    parameter int tRCD     = 16,
    parameter int tRP      = 16,
    parameter int tRAS     = 39
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                i_act,
    input  logic                i_pre,
    input  logic                i_rdwr_ap,
    input  logic [ROW_BITS-1:0] i_row,
    output logic                o_idle,
    output logic                o_active,
    output logic                o_trp_busy,
    output logic                o_rcd_busy,
    output logic                o_ras_busy,
    output logic [ROW_BITS-1:0] o_row
);
    localparam int RCD_W = $clog2(tRCD + 1);
    localparam int RP_W  = $clog2(tRP + 1);
    localparam int RAS_W = $clog2(tRAS + 1);
    localparam logic [RCD_W-1:0] RCD_INIT = RCD_W'(tRCD - 1);
    localparam logic [RP_W-1:0]  RP_INIT  = RP_W'(tRP - 1);
    localparam logic [RAS_W-1:0] RAS_INIT = RAS_W'(tRAS - 1);

    bank_state_t         r_state, w_state_nxt;
    logic [ROW_BITS-1:0] r_row, w_row_nxt;
    logic [RCD_W-1:0]    r_rcd, w_rcd_nxt;
    logic [RP_W-1:0]     r_rp, w_rp_nxt;
    logic [RAS_W-1:0]    r_ras, w_ras_nxt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= BANK_IDLE;
            r_row   <= '0;
            r_rcd   <= '0;
            r_rp    <= '0;
            r_ras   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_rcd   <= w_rcd_nxt;
            r_rp    <= w_rp_nxt;
            r_ras   <= w_ras_nxt;
        end
    end

    // A PRE/PREA reaching a non-IDLE bank reloads rp even when rp expires on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_rcd_nxt   = (r_rcd != '0) ? r_rcd - 1'b1 : r_rcd;
        w_rp_nxt    = (r_rp != '0) ? r_rp - 1'b1 : r_rp;
        w_ras_nxt   = (r_ras != '0) ? r_ras - 1'b1 : r_ras;
        if (i_act) begin
            w_state_nxt = BANK_ACTIVE;
            w_row_nxt   = i_row;
            w_rcd_nxt   = RCD_INIT;
            w_ras_nxt   = RAS_INIT;
        end else if ((i_pre && r_state != BANK_IDLE) || (i_rdwr_ap && r_state == BANK_ACTIVE)) begin
            w_state_nxt = BANK_PRECH;
            w_rp_nxt    = RP_INIT;
        end else if (r_state == BANK_PRECH && r_rp == '0) begin
            w_state_nxt = BANK_IDLE;
        end
    end

    // A bank whose rp reaches 0 counts as idle on that very edge.
    assign o_idle     = r_state == BANK_IDLE || (r_state == BANK_PRECH && r_rp == '0);
    assign o_active   = r_state == BANK_ACTIVE;
    assign o_trp_busy = r_state == BANK_PRECH && r_rp != '0;
    assign o_rcd_busy = r_rcd != '0;
    assign o_ras_busy = r_ras != '0;
    assign o_row      = r_row;
endmodule

// File: rtl/dram_cmd_decode.sv
// dram_cmd_decode: DDR4 command/address bus receiver - decode, bank tracking, timing-violation flags
// Ports: CLK, nRST (async active-low), CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, BG, BA,
// ADDR in; cmd_valid/cmd_type/cmd_bank/cmd_row/cmd_col/cmd_ap decoded command, err_valid/err_code
// violation, err_count saturating error count, bank_open ACTIVE bank mask. Latency 1 cycle.
module dram_cmd_decode
    import dram_pkg::*;
#(
    parameter int BG_BITS  = 1,
    parameter int BA_BITS  = 2,
    parameter int ROW_BITS = 16,
    parameter int COL_BITS = 10,
    parameter int tRCD     = 16,
    parameter int tRP      = 16,
    parameter int tRAS     = 39,
    parameter int tRFC     = 280
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        CKE,
    input  logic                        CS_n,
    input  logic                        ACT_n,
    input  logic                        RAS_n_A16,
    input  logic                        CAS_n_A15,
    input  logic                        WE_n_A14,
    input  logic [BG_BITS-1:0]          BG,
    input  logic [BA_BITS-1:0]          BA,
    input  logic [13:0]                 ADDR,
    output logic                        cmd_valid,
    output cmd_t                        cmd_type,
    output logic [BG_BITS+BA_BITS-1:0]  cmd_bank,
    output logic [ROW_BITS-1:0]         cmd_row,
    output logic [COL_BITS-1:0]         cmd_col,
    output logic                        cmd_ap,
    output logic                        err_valid,
    output err_t                        err_code,
    output logic [15:0]                 err_count,
    output logic [2**(BG_BITS+BA_BITS)-1:0] bank_open
);
    localparam int BANK_W  = BG_BITS + BA_BITS;
    localparam int N_BANKS = 2 ** BANK_W;
    localparam int RFC_W   = $clog2(tRFC + 1);
    localparam logic [RFC_W-1:0] RFC_INIT = RFC_W'(tRFC - 1);

    cmd_t                w_cmd;
    err_t                w_err;
    logic [BANK_W-1:0]   w_bank;
    logic [N_BANKS-1:0]  w_bank_sel, w_idle, w_active, w_trp_busy, w_rcd_busy, w_ras_busy, w_tras_viol;
    logic [ROW_BITS-1:0] w_row_in;
    logic [ROW_BITS-1:0] w_row [N_BANKS];
    logic                w_is_rdwr, w_ap;
    logic [RFC_W-1:0]    r_rfc;
    logic                r_cmd_valid, r_cmd_ap, r_err_valid;
    cmd_t                r_cmd_type;
    err_t                r_err_code;
    logic [BANK_W-1:0]   r_cmd_bank;
    logic [ROW_BITS-1:0] r_cmd_row;
    logic [COL_BITS-1:0] r_cmd_col;
    logic [15:0]         r_err_count;

    assign w_cmd       = (!CS_n && CKE) ? decode_cmd(ACT_n, {RAS_n_A16, CAS_n_A15, WE_n_A14}, ADDR[AP_BIT]) : CMD_NONE;
    assign w_bank      = {BG, BA};
    assign w_bank_sel  = N_BANKS'(1) << w_bank;
    assign w_row_in    = ROW_BITS'({RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR});
    assign w_is_rdwr   = w_cmd == CMD_RD || w_cmd == CMD_WR;
    assign w_ap        = w_is_rdwr && ADDR[AP_BIT];
    assign w_tras_viol = w_active & w_ras_busy;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        dram_bank_fsm #(
            .ROW_BITS(ROW_BITS),
            .tRCD    (tRCD),
            .tRP     (tRP),
            .tRAS    (tRAS)
        ) u_bank (
            .CLK       (CLK),
            .nRST      (nRST),
            .i_act     (w_cmd == CMD_ACT && w_bank_sel[b]),
            .i_pre     ((w_cmd == CMD_PRE && w_bank_sel[b]) || w_cmd == CMD_PREA),
            .i_rdwr_ap (w_ap && w_bank_sel[b]),
            .i_row     (w_row_in),
            .o_idle    (w_idle[b]),
            .o_active  (w_active[b]),
            .o_trp_busy(w_trp_busy[b]),
            .o_rcd_busy(w_rcd_busy[b]),
            .o_ras_busy(w_ras_busy[b]),
            .o_row     (w_row[b])
        );
    end

    // Each command class can raise only its own codes, so priority reduces to RFC first.
    always_comb begin
        w_err = ERR_NONE;
        if (w_cmd != CMD_NONE) begin
            if (r_rfc != '0) w_err = ERR_RFC_BUSY;
            else case (w_cmd)
                CMD_ACT:        w_err = w_trp_busy[w_bank] ? ERR_TRP : !w_idle[w_bank] ? ERR_ACT_OPEN : ERR_NONE;
                CMD_RD, CMD_WR: w_err = !w_active[w_bank] ? ERR_NOT_OPEN : w_rcd_busy[w_bank] ? ERR_TRCD : ERR_NONE;
                CMD_PRE:        w_err = w_tras_viol[w_bank] ? ERR_TRAS : ERR_NONE;
                CMD_PREA:       w_err = |w_tras_viol ? ERR_TRAS : ERR_NONE;
                CMD_REF:        w_err = !(&w_idle) ? ERR_REF_OPEN : ERR_NONE;
                CMD_RFU:        w_err = ERR_RFU;
                default:        w_err = ERR_NONE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rfc       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= CMD_NONE;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
            r_cmd_ap    <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= '0;
        end else begin
            r_rfc       <= (w_cmd == CMD_REF) ? RFC_INIT : (r_rfc != '0) ? r_rfc - 1'b1 : r_rfc;
            r_cmd_valid <= w_cmd != CMD_NONE;
            r_cmd_type  <= w_cmd;
            r_cmd_bank  <= (w_cmd != CMD_NONE) ? w_bank : '0;
            r_cmd_row   <= (w_cmd == CMD_ACT) ? w_row_in : (w_is_rdwr && w_active[w_bank]) ? w_row[w_bank] : '0;
            r_cmd_col   <= w_is_rdwr ? ADDR[COL_BITS-1:0] : '0;
            r_cmd_ap    <= w_ap;
            r_err_valid <= w_err != ERR_NONE;
            r_err_code  <= w_err;
            if (w_err != ERR_NONE && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_type  = r_cmd_type;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign cmd_ap    = r_cmd_ap;
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign err_count = r_err_count;
    assign bank_open = w_active;
endmodule

// File: tb/tb_dram_cmd_decode.sv
// tb_dram_cmd_decode: directed self-checking bench for dram_cmd_decode
module tb_dram_cmd_decode;
    import dram_pkg::*;
    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        CKE = 1'b1;
    logic        CS_n = 1'b1;
    logic        ACT_n = 1'b1;
    logic        RAS_n_A16 = 1'b1;
    logic        CAS_n_A15 = 1'b1;
    logic        WE_n_A14 = 1'b1;
    logic [0:0]  BG = '0;
    logic [1:0]  BA = '0;
    logic [13:0] ADDR = '0;
    logic        cmd_valid, cmd_ap, err_valid;
    cmd_t        cmd_type;
    err_t        err_code;
    logic [2:0]  cmd_bank;
    logic [15:0] cmd_row, err_count;
    logic [9:0]  cmd_col;
    logic [7:0]  bank_open;
    int total = 0;
    int bad = 0;

    dram_cmd_decode dut (
        .CLK(CLK), .nRST(nRST), .CKE(CKE), .CS_n(CS_n), .ACT_n(ACT_n),
        .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
        .BG(BG), .BA(BA), .ADDR(ADDR),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .cmd_ap(cmd_ap), .err_valid(err_valid), .err_code(err_code),
        .err_count(err_count), .bank_open(bank_open)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle; returns at the following negedge, where that cycle's result is visible.
    task automatic bus(input logic cs, input logic cke, input logic actn, input logic ras,
                       input logic cas, input logic we, input logic [2:0] bank, input logic [13:0] addr);
        CS_n = cs; CKE = cke; ACT_n = actn; RAS_n_A16 = ras; CAS_n_A15 = cas; WE_n_A14 = we;
        {BG, BA} = bank; ADDR = addr;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1, 1, 1, 1, 1, 1, 3'd0, 14'h0);
    endtask

    // Next command lands k edges after the previous one.
    task automatic gap(input int k);
        idle(k - 1);
    endtask

    task automatic act(input logic [2:0] b, input logic [15:0] row);
        bus(0, 1, 0, 0, row[15], row[14], b, row[13:0]);
    endtask

    task automatic rd(input logic [2:0] b, input logic [9:0] col, input logic ap);
        bus(0, 1, 1, 1, 0, 1, b, {3'b000, ap, col});
    endtask

    task automatic wr(input logic [2:0] b, input logic [9:0] col);
        bus(0, 1, 1, 1, 0, 0, b, {4'b0000, col});
    endtask

    task automatic pre(input logic [2:0] b);
        bus(0, 1, 1, 0, 1, 0, b, 14'h0000);
    endtask

    task automatic prea();
        bus(0, 1, 1, 0, 1, 0, 3'd0, 14'h0400);
    endtask

    task automatic refresh();
        bus(0, 1, 1, 0, 0, 1, 3'd0, 14'h0000);
    endtask

    task automatic rst_pulse();
        nRST = 1'b0;
        idle(2);
        nRST = 1'b1;
    endtask

    initial begin
        #2 nRST = 1'b0;
        @(negedge CLK);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_type", 32'(cmd_type), 32'(CMD_NONE));
        chk("rst_count", 32'(err_count), 0);
        chk("rst_open", 32'(bank_open), 0);
        nRST = 1'b1;

        act(3'd3, 16'h1234);
        chk("t1_act_type", 32'(cmd_type), 32'(CMD_ACT));
        chk("t1_act_bank", 32'(cmd_bank), 3);
        chk("t1_act_row", 32'(cmd_row), 32'h1234);
        chk("t1_open", 32'(bank_open), 32'h08);
        gap(16); rd(3'd3, 10'h040, 1'b0);
        chk("t1_rd_type", 32'(cmd_type), 32'(CMD_RD));
        chk("t1_rd_row", 32'(cmd_row), 32'h1234);
        chk("t1_rd_col", 32'(cmd_col), 32'h40);
        chk("t1_rd_err", 32'(err_valid), 0);
        chk("t1_rd_ap", 32'(cmd_ap), 0);
        idle(1);
        chk("t1_des_valid", 32'(cmd_valid), 0);

        act(3'd0, 16'h0011);
        gap(15); rd(3'd0, 10'h005, 1'b0);
        chk("t2_trcd_err", 32'(err_valid), 1);
        chk("t2_trcd_code", 32'(err_code), 32'(ERR_TRCD));
        chk("t2_trcd_count", 32'(err_count), 1);
        gap(23); pre(3'd0);
        chk("t2_tras_code", 32'(err_code), 32'(ERR_TRAS));
        chk("t2_tras_count", 32'(err_count), 2);
        chk("t2_tras_open", 32'(bank_open), 32'h08);
        rst_pulse();
        act(3'd0, 16'h0011);
        gap(39); pre(3'd0);
        chk("t2_pre_type", 32'(cmd_type), 32'(CMD_PRE));
        chk("t2_pre_err", 32'(err_valid), 0);
        chk("t2_pre_open", 32'(bank_open), 0);
        wr(3'd0, 10'h001);
        chk("t2_wr_closed", 32'(err_code), 32'(ERR_NOT_OPEN));
        chk("t2_wr_count", 32'(err_count), 1);

        rst_pulse();
        act(3'd5, 16'h0077);
        gap(16); rd(3'd5, 10'h008, 1'b1);
        chk("t3_ap", 32'(cmd_ap), 1);
        chk("t3_col", 32'(cmd_col), 8);
        chk("t3_rd_err", 32'(err_valid), 0);
        chk("t3_prech", 32'(bank_open), 0);
        gap(15); act(3'd5, 16'h0077);
        chk("t3_trp", 32'(err_code), 32'(ERR_TRP));
        rst_pulse();
        act(3'd5, 16'h0077);
        gap(16); rd(3'd5, 10'h008, 1'b1);
        gap(16); act(3'd5, 16'hBEEF);
        chk("t3_act_ok", 32'(err_valid), 0);
        chk("t3_act_open", 32'(bank_open), 32'h20);
        chk("t3_act_row", 32'(cmd_row), 32'hBEEF);

        rst_pulse();
        act(3'd1, 16'h0001);
        act(3'd6, 16'h0006);
        idle(40);
        prea();
        chk("t4_prea_type", 32'(cmd_type), 32'(CMD_PREA));
        chk("t4_prea_err", 32'(err_valid), 0);
        chk("t4_prea_open", 32'(bank_open), 0);
        gap(16); refresh();
        chk("t4_ref_type", 32'(cmd_type), 32'(CMD_REF));
        chk("t4_ref_err", 32'(err_valid), 0);
        gap(279); act(3'd2, 16'h0002);
        chk("t4_rfc_code", 32'(err_code), 32'(ERR_RFC_BUSY));
        chk("t4_rfc_count", 32'(err_count), 1);
        act(3'd4, 16'h0004);
        chk("t4_rfc_done", 32'(err_valid), 0);
        chk("t4_open", 32'(bank_open), 32'h14);
        refresh();
        chk("t4_ref_open", 32'(err_code), 32'(ERR_REF_OPEN));
        chk("t4_ref_count", 32'(err_count), 2);

        nRST = 1'b0;
        #1;
        chk("t6_valid", 32'(cmd_valid), 0);
        chk("t6_type", 32'(cmd_type), 32'(CMD_NONE));
        chk("t6_err", 32'(err_valid), 0);
        chk("t6_code", 32'(err_code), 32'(ERR_NONE));
        chk("t6_count", 32'(err_count), 0);
        chk("t6_open", 32'(bank_open), 0);
        @(negedge CLK);
        nRST = 1'b1;
        act(3'd7, 16'h0007);
        chk("t6_act_valid", 32'(cmd_valid), 1);
        chk("t6_act_err", 32'(err_valid), 0);
        chk("t6_act_open", 32'(bank_open), 32'h80);

        bus(1, 1, 0, 0, 0, 0, 3'd1, 14'h0000);
        chk("t5_cs_valid", 32'(cmd_valid), 0);
        chk("t5_cs_open", 32'(bank_open), 32'h80);
        bus(0, 0, 0, 0, 0, 0, 3'd1, 14'h0000);
        chk("t5_cke_valid", 32'(cmd_valid), 0);
        chk("t5_cke_open", 32'(bank_open), 32'h80);
        bus(0, 1, 1, 0, 1, 1, 3'd0, 14'h0000);
        chk("t5_rfu_type", 32'(cmd_type), 32'(CMD_RFU));
        chk("t5_rfu_code", 32'(err_code), 32'(ERR_RFU));
        bus(0, 1, 1, 1, 1, 1, 3'd0, 14'h0000);
        chk("t5_nop_valid", 32'(cmd_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
